// File: rtl/packet_tx_scheduler.sv
// packet_tx_scheduler: descriptor FIFO that issues one packet at a time
// to the packet-buffer streamer and enforces the inter-frame gap.
module packet_tx_scheduler #(
   parameter int RAM_SIZE    = 2048,
   parameter int QUEUE_DEPTH = 4,
   parameter int IFG_CYCLES  = 48
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             enq,
   input  logic [$clog2(RAM_SIZE)-1:0]      enq_start,
   input  logic [$clog2(RAM_SIZE)-1:0]      enq_end,
   input  logic                             hold,
   input  logic                             stream_done,
   output logic                             stream_start,
   output logic [$clog2(RAM_SIZE)-1:0]      stream_read_start,
   output logic [$clog2(RAM_SIZE)-1:0]      stream_read_end,
   output logic                             full,
   output logic [$clog2(QUEUE_DEPTH+1)-1:0] count,
   output logic                             busy,
   output logic                             skip,
   output logic                             overflow
);

   localparam int AW = $clog2(RAM_SIZE);
   localparam int PW = $clog2(QUEUE_DEPTH);
   localparam int CW = $clog2(QUEUE_DEPTH + 1);
   localparam int GW = $clog2(IFG_CYCLES + 1);

   localparam logic [PW:0]   L_DEPTH    = (PW + 1)'(QUEUE_DEPTH);
   localparam logic [GW-1:0] L_GAP_LOAD = GW'(IFG_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACTIVE,
      S_GAP
   } state_t;

   state_t r_state;
   state_t w_state_nxt;

   logic [AW-1:0] r_q_start [QUEUE_DEPTH];
   logic [AW-1:0] r_q_end   [QUEUE_DEPTH];

   logic [PW:0]   r_wptr;
   logic [PW:0]   r_rptr;
   logic [PW:0]   w_wptr_nxt;
   logic [PW:0]   w_rptr_nxt;
   logic [PW:0]   w_fill_nxt;

   logic [GW-1:0] r_gap;

   logic [AW-1:0] w_head_start;
   logic [AW-1:0] w_head_end;
   logic          w_head_zero;
   logic          w_can_pop;
   logic          w_push;
   logic          w_pop;
   logic          w_issue;
   logic          w_skip;
   logic          w_load_gap;

   // Queue head view and push/pop qualification
   always_comb begin
      w_head_start = r_q_start[r_rptr[PW-1:0]];
      w_head_end   = r_q_end[r_rptr[PW-1:0]];
      w_head_zero  = (w_head_start == w_head_end);
      w_push       = enq & ~full;
      w_can_pop    = (r_state == S_IDLE)
                   & (count != '0)
                   & ~hold;
   end

   // Next pointer values; full/count follow the pointers
   always_comb begin
      w_wptr_nxt = w_push ? r_wptr + 1'b1 : r_wptr;
      w_rptr_nxt = w_pop  ? r_rptr + 1'b1 : r_rptr;
      w_fill_nxt = w_wptr_nxt - w_rptr_nxt;
   end

   // Descriptor storage, written on accepted enq
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_q_start[r_wptr[PW-1:0]] <= enq_start;
         r_q_end[r_wptr[PW-1:0]]   <= enq_end;
      end
   end

   // Queue pointers with registered full and count
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wptr <= '0;
         r_rptr <= '0;
         full   <= 1'b0;
         count  <= '0;
      end else begin
         r_wptr <= w_wptr_nxt;
         r_rptr <= w_rptr_nxt;
         full   <= (w_fill_nxt == L_DEPTH);
         count  <= CW'(w_fill_nxt);
      end
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // FSM next-state logic
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         S_IDLE: begin
            if (w_can_pop && !w_head_zero) begin
               w_state_nxt = S_ACTIVE;
            end
         end
         S_ACTIVE: begin
            if (stream_done) begin
               w_state_nxt = S_GAP;
            end
         end
         S_GAP: begin
            if (r_gap == '0) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // FSM outputs: pop, issue, discard and gap load strobes
   always_comb begin
      w_pop      = 1'b0;
      w_issue    = 1'b0;
      w_skip     = 1'b0;
      w_load_gap = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            w_pop   = w_can_pop;
            w_issue = w_can_pop & ~w_head_zero;
            w_skip  = w_can_pop & w_head_zero;
         end
         S_ACTIVE: begin
            w_load_gap = stream_done;
         end
         S_GAP: begin
         end
         default: begin
         end
      endcase
   end

   // Inter-frame gap down-counter
   always_ff @(posedge clk) begin
      if (rst) begin
         r_gap <= '0;
      end else if (w_load_gap) begin
         r_gap <= L_GAP_LOAD;
      end else if (r_state == S_GAP && r_gap != '0) begin
         r_gap <= r_gap - 1'b1;
      end
   end

   // Registered streamer handshake, skip pulse and sticky overflow
   always_ff @(posedge clk) begin
      if (rst) begin
         stream_start      <= 1'b0;
         stream_read_start <= '0;
         stream_read_end   <= '0;
         skip              <= 1'b0;
         overflow          <= 1'b0;
      end else begin
         stream_start <= w_issue;
         skip         <= w_skip;
         if (w_issue) begin
            stream_read_start <= w_head_start;
            stream_read_end   <= w_head_end;
         end
         if (enq && full) begin
            overflow <= 1'b1;
         end
      end
   end

   assign busy = (r_state != S_IDLE);

endmodule
